board_manager: RTL and testbench

- Holds the live 9x9 Sudoku board and drives the board/board_blank buses consumed by the VGA top.
- Accepts three kinds of input:
  - puzzle loads from the stage/puzzle ROM logic;
  - single-cell writes from the handwriting recogniser;
  - check requests.
- A check is a sequential row/column/box validation scan that reports solved/conflict status to game control.

---
 rtl/board_if.sv | 36 +++
 rtl/board_manager.sv | 172 +++++++++++++++++
 tb/tb_board_manager.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/board_if.sv
// Bus bundle between the board manager and its clients: puzzle load,
// single-cell writes, check requests, and the live board and status outputs.
interface board_if;
   logic         load_valid;
   logic [323:0] load_board;
   logic [80:0]  load_fixed;
   logic         wr_valid;
   logic [6:0]   wr_idx;
   logic [3:0]   wr_digit;
   logic         wr_ready;
   logic         wr_reject;
   logic         check_start;
   logic         busy;
   logic         check_done;
   logic         solved;
   logic         conflict;
   logic [4:0]   conflict_grp;
   logic [323:0] board;
   logic [80:0]  board_blank;

   // Client side: issues loads, writes and check requests.
   modport master (
      output load_valid, load_board, load_fixed,
      output wr_valid, wr_idx, wr_digit, check_start,
      input  wr_ready, wr_reject, busy, check_done,
      input  solved, conflict, conflict_grp, board, board_blank
   );

   // Board manager side.
   modport slave (
      input  load_valid, load_board, load_fixed,
      input  wr_valid, wr_idx, wr_digit, check_start,
      output wr_ready, wr_reject, busy, check_done,
      output solved, conflict, conflict_grp, board, board_blank
   );
endinterface

// File: rtl/board_manager.sv
// Live 9x9 Sudoku board with puzzle load, per-cell writes and a
// 27-cycle row/column/box validation scan reporting solved/conflict.
module board_manager #(
   parameter bit CHECK_ON_WRITE = 1'b1
) (
   input logic    clk,
   input logic    rst,
   board_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} state_t;

   state_t      state_q;
   logic [3:0]  cell_q [0:80];
   logic [80:0] fixed_q;
   logic [80:0] blank_q;
   logic [4:0]  grp_q;
   logic [4:0]  conflict_grp_q;
   logic        dup_q;
   logic        zero_q;
   logic        done_q;
   logic        reject_q;
   logic        solved_q;
   logic        conflict_q;

   logic        grp_dup;
   logic        grp_zero;
   logic        dup_d;
   logic        zero_d;
   logic        wr_bad;
   logic [15:0] seen;
   logic [6:0]  scan_idx;
   logic [3:0]  scan_digit;

   // Cell index of member k (0-8) of group g: rows 0-8, columns 9-17, boxes 18-26.
   function automatic logic [6:0] cell_index(input logic [4:0] g, input int k);
      int gn;
      int r;
      int c;
      int b;
      gn = int'(g);
      if (gn < 9) begin
         r = gn;
         c = k;
      end else if (gn < 18) begin
         r = k;
         c = gn - 9;
      end else begin
         b = gn - 18;
         r = 3 * (b / 3) + k / 3;
         c = 3 * (b % 3) + k % 3;
      end
      return 7'(r * 9 + c);
   endfunction

   // Evaluate the group selected by grp_q: duplicate among nonzero digits, or any blank.
   always_comb begin
      grp_dup    = 1'b0;
      grp_zero   = 1'b0;
      seen       = '0;
      scan_idx   = '0;
      scan_digit = '0;
      for (int k = 0; k < 9; k++) begin
         scan_idx   = cell_index(grp_q, k);
         scan_digit = cell_q[scan_idx];
         if (scan_digit == 4'd0) begin
            grp_zero = 1'b1;
         end else begin
            if (seen[scan_digit]) grp_dup = 1'b1;
            seen[scan_digit] = 1'b1;
         end
      end
   end

   assign dup_d  = dup_q | grp_dup;
   assign zero_d = zero_q | grp_zero;
   // Out-of-range index is tested first so the fixed-mask lookup only matters for real cells.
   assign wr_bad = (bus.wr_idx > 7'd80) || (bus.wr_digit > 4'd9) || fixed_q[bus.wr_idx];

   // Main FSM: load (any state) > write > check start in IDLE; group scan in CHECK.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         for (int i = 0; i < 81; i++) cell_q[i] <= 4'd0;
         fixed_q        <= '0;
         blank_q        <= '1;
         grp_q          <= '0;
         conflict_grp_q <= '0;
         dup_q          <= 1'b0;
         zero_q         <= 1'b0;
         done_q         <= 1'b0;
         reject_q       <= 1'b0;
         solved_q       <= 1'b0;
         conflict_q     <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         reject_q <= 1'b0;
         if (bus.load_valid) begin
            // A load also aborts any scan in progress without a done pulse.
            for (int i = 0; i < 81; i++) begin
               if (bus.load_board[4*i +: 4] > 4'd9) begin
                  cell_q[i]  <= 4'd0;
                  blank_q[i] <= 1'b1;
               end else begin
                  cell_q[i]  <= bus.load_board[4*i +: 4];
                  blank_q[i] <= (bus.load_board[4*i +: 4] == 4'd0);
               end
            end
            fixed_q        <= bus.load_fixed;
            state_q        <= IDLE;
            solved_q       <= 1'b0;
            conflict_q     <= 1'b0;
            conflict_grp_q <= '0;
         end else if (state_q == IDLE) begin
            if (bus.wr_valid) begin
               if (wr_bad) begin
                  reject_q <= 1'b1;
               end else begin
                  cell_q[bus.wr_idx]  <= bus.wr_digit;
                  blank_q[bus.wr_idx] <= (bus.wr_digit == 4'd0);
                  solved_q            <= 1'b0;
                  conflict_q          <= 1'b0;
                  conflict_grp_q      <= '0;
                  if (CHECK_ON_WRITE) begin
                     state_q <= CHECK;
                     grp_q   <= '0;
                     dup_q   <= 1'b0;
                     zero_q  <= 1'b0;
                  end
               end
            end else if (bus.check_start) begin
               state_q        <= CHECK;
               grp_q          <= '0;
               dup_q          <= 1'b0;
               zero_q         <= 1'b0;
               solved_q       <= 1'b0;
               conflict_q     <= 1'b0;
               conflict_grp_q <= '0;
            end
         end else begin
            // Only the first failing group is remembered.
            if (grp_dup && !dup_q) conflict_grp_q <= grp_q;
            dup_q  <= dup_d;
            zero_q <= zero_d;
            if (grp_q == 5'd26) begin
               state_q    <= IDLE;
               done_q     <= 1'b1;
               conflict_q <= dup_d;
               solved_q   <= !dup_d && !zero_d;
            end else begin
               grp_q <= grp_q + 5'd1;
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 81; gi++) begin : g_cell
         assign bus.board[4*gi +: 4] = cell_q[gi];
      end
   endgenerate

   assign bus.board_blank  = blank_q;
   assign bus.wr_ready     = (state_q == IDLE);
   assign bus.busy         = (state_q == CHECK);
   assign bus.wr_reject    = reject_q;
   assign bus.check_done   = done_q;
   assign bus.solved       = solved_q;
   assign bus.conflict     = conflict_q;
   assign bus.conflict_grp = conflict_grp_q;

endmodule

// File: tb/tb_board_manager.sv
// Directed test of board_manager: load, write rejection, scan latency,
// conflict reporting, load abort, blank tracking and mid-scan reset.
module tb_board_manager;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   board_if bus();

   board_manager #(.CHECK_ON_WRITE(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [323:0] grid;
   logic [323:0] partial;
   logic [323:0] b2;
   logic [80:0]  pblank;
   logic [80:0]  ones81;
   int           cyc;
   int           bcyc;
   int           npulse;

   task automatic chk(input string tag, input logic [323:0] obs, input logic [323:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [323:0] b, input logic [80:0] f);
      bus.load_board = b;
      bus.load_fixed = f;
      bus.load_valid = 1'b1;
      step();
      bus.load_valid = 1'b0;
      $display("load   : busy=%0b solved=%0b conflict=%0b", bus.busy, bus.solved, bus.conflict);
   endtask

   task automatic do_write(input logic [6:0] idx, input logic [3:0] dig);
      bus.wr_idx   = idx;
      bus.wr_digit = dig;
      bus.wr_valid = 1'b1;
      step();
      bus.wr_valid = 1'b0;
      $display("write  : idx=%0d digit=%0d reject=%0b busy=%0b", idx, dig, bus.wr_reject, bus.busy);
   endtask

   task automatic do_check();
      bus.check_start = 1'b1;
      step();
      bus.check_start = 1'b0;
      $display("check  : busy=%0b", bus.busy);
   endtask

   // Steps until check_done with a 40-cycle bound; returns cycles taken and busy cycles seen.
   task automatic run_to_done(output int cycles, output int busy_cycles);
      cycles = 0;
      busy_cycles = 0;
      while (bus.check_done !== 1'b1 && cycles < 40) begin
         if (bus.busy === 1'b1) busy_cycles++;
         step();
         cycles++;
      end
      $display("done   : cycles=%0d solved=%0b conflict=%0b grp=%0d",
               cycles, bus.solved, bus.conflict, bus.conflict_grp);
   endtask

   initial begin
      // Known valid solution: cell(r,c) = ((3r + r/3 + c) mod 9) + 1
      for (int i = 0; i < 81; i++) begin
         grid[4*i +: 4] = 4'((((i / 9) * 3 + (i / 9) / 3 + (i % 9)) % 9) + 1);
      end
      partial = grid;
      partial[3:0]     = 4'd0;
      partial[163:160] = 4'd0;
      partial[323:320] = 4'd0;
      pblank = '0;
      pblank[0]  = 1'b1;
      pblank[40] = 1'b1;
      pblank[80] = 1'b1;
      ones81 = '1;

      rst = 1'b1;
      bus.load_valid  = 1'b0;
      bus.load_board  = '0;
      bus.load_fixed  = '0;
      bus.wr_valid    = 1'b0;
      bus.wr_idx      = '0;
      bus.wr_digit    = '0;
      bus.check_start = 1'b0;
      step();
      step();

      // Reset state
      chk("rst_board",    bus.board, 324'd0);
      chk("rst_blank",    324'(bus.board_blank), 324'(ones81));
      chk("rst_ready",    324'(bus.wr_ready), 324'd1);
      chk("rst_busy",     324'(bus.busy), 324'd0);
      chk("rst_done",     324'(bus.check_done), 324'd0);
      chk("rst_reject",   324'(bus.wr_reject), 324'd0);
      chk("rst_solved",   324'(bus.solved), 324'd0);
      chk("rst_conflict", 324'(bus.conflict), 324'd0);
      chk("rst_grp",      324'(bus.conflict_grp), 324'd0);
      rst = 1'b0;
      step();

      // 1: complete valid grid -> solved after 27 scan cycles
      do_load(grid, '0);
      chk("t1_board", bus.board, grid);
      chk("t1_blank", 324'(bus.board_blank), 324'd0);
      do_check();
      chk("t1_busy", 324'(bus.busy), 324'd1);
      chk("t1_ready", 324'(bus.wr_ready), 324'd0);
      run_to_done(cyc, bcyc);
      chk("t1_latency",  324'(cyc), 324'd27);
      chk("t1_busycyc",  324'(bcyc), 324'd27);
      chk("t1_done",     324'(bus.check_done), 324'd1);
      chk("t1_solved",   324'(bus.solved), 324'd1);
      chk("t1_conflict", 324'(bus.conflict), 324'd0);
      chk("t1_idle",     324'(bus.busy), 324'd0);
      step();
      chk("t1_done_pulse", 324'(bus.check_done), 324'd0);
      chk("t1_hold",       324'(bus.solved), 324'd1);

      // 5: check start clears status; load at T+10 aborts the scan
      do_check();
      chk("t5_clear", 324'(bus.solved), 324'd0);
      repeat (9) step();
      do_load(partial, '0);
      chk("t5_busy",  324'(bus.busy), 324'd0);
      chk("t5_board", bus.board, partial);
      chk("t5_blank", 324'(bus.board_blank), 324'(pblank));
      npulse = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.check_done === 1'b1) npulse++;
         step();
      end
      chk("t5_no_done",  324'(npulse), 324'd0);
      chk("t5_solved",   324'(bus.solved), 324'd0);
      chk("t5_conflict", 324'(bus.conflict), 324'd0);

      // 4: partial board without duplicates
      do_check();
      run_to_done(cyc, bcyc);
      chk("t4_latency",  324'(cyc), 324'd27);
      chk("t4_done",     324'(bus.check_done), 324'd1);
      chk("t4_solved",   324'(bus.solved), 324'd0);
      chk("t4_conflict", 324'(bus.conflict), 324'd0);

      // 2: fixed cell and out-of-range writes are refused; digit > 9 loads as 0
      b2 = '0;
      b2[3:0] = 4'd5;
      b2[7:4] = 4'hC;
      do_load(b2, 81'd1);
      chk("t2_load_board", bus.board, 324'h5);
      chk("t2_load_blank", 324'(bus.board_blank), 324'(ones81 & ~81'd1));
      do_write(7'd0, 4'd3);
      chk("t2_rej_fixed", 324'(bus.wr_reject), 324'd1);
      chk("t2_cell0",     324'(bus.board[3:0]), 324'd5);
      chk("t2_nobusy",    324'(bus.busy), 324'd0);
      step();
      chk("t2_rej_pulse", 324'(bus.wr_reject), 324'd0);
      do_write(7'd81, 4'd1);
      chk("t2_rej_idx", 324'(bus.wr_reject), 324'd1);
      do_write(7'd1, 4'd10);
      chk("t2_rej_dig", 324'(bus.wr_reject), 324'd1);
      chk("t2_board",   bus.board, 324'h5);

      // 6: write/erase cell 40; a write during the scan is ignored
      do_load('0, '0);
      do_write(7'd40, 4'd9);
      chk("t6_digit", 324'(bus.board[163:160]), 324'd9);
      chk("t6_blank", 324'(bus.board_blank[40]), 324'd0);
      chk("t6_busy",  324'(bus.busy), 324'd1);
      bus.wr_idx   = 7'd41;
      bus.wr_digit = 4'd3;
      bus.wr_valid = 1'b1;
      step();
      bus.wr_valid = 1'b0;
      chk("t6_ign_reject", 324'(bus.wr_reject), 324'd0);
      chk("t6_ign_cell",   324'(bus.board[167:164]), 324'd0);
      run_to_done(cyc, bcyc);
      chk("t6_latency", 324'(cyc), 324'd26);
      chk("t6_conflict", 324'(bus.conflict), 324'd0);
      do_write(7'd40, 4'd0);
      chk("t6_erase",       324'(bus.board[163:160]), 324'd0);
      chk("t6_erase_blank", 324'(bus.board_blank[40]), 324'd1);
      run_to_done(cyc, bcyc);
      chk("t6_latency2", 324'(cyc), 324'd27);

      // 3: two 7s in box 0 -> conflict group 18
      do_load('0, '0);
      do_write(7'd10, 4'd7);
      run_to_done(cyc, bcyc);
      chk("t3_first_conflict", 324'(bus.conflict), 324'd0);
      do_write(7'd20, 4'd7);
      chk("t3_wr_clear", 324'(bus.conflict), 324'd0);
      run_to_done(cyc, bcyc);
      chk("t3_latency",  324'(cyc), 324'd27);
      chk("t3_conflict", 324'(bus.conflict), 324'd1);
      chk("t3_grp",      324'(bus.conflict_grp), 324'd18);
      chk("t3_solved",   324'(bus.solved), 324'd0);
      step();
      chk("t3_hold", 324'(bus.conflict), 324'd1);
      // Two 3s in row 0 as well: the earliest failing group (row 0) wins
      do_write(7'd1, 4'd3);
      run_to_done(cyc, bcyc);
      chk("t3_grp_box", 324'(bus.conflict_grp), 324'd18);
      do_write(7'd2, 4'd3);
      run_to_done(cyc, bcyc);
      chk("t3_grp_row", 324'(bus.conflict_grp), 324'd0);
      chk("t3_conflict2", 324'(bus.conflict), 324'd1);
      do_load(grid, '0);
      chk("t3_load_conflict", 324'(bus.conflict), 324'd0);
      chk("t3_load_grp",      324'(bus.conflict_grp), 324'd0);

      // Reset in the middle of a scan
      do_check();
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      $display("reset  : busy=%0b", bus.busy);
      chk("mid_rst_busy",  324'(bus.busy), 324'd0);
      chk("mid_rst_board", bus.board, 324'd0);
      chk("mid_rst_blank", 324'(bus.board_blank), 324'(ones81));
      step();
      chk("mid_rst_done", 324'(bus.check_done), 324'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
